// File: rtl/ct_ciu_regs_piu_arb_if.sv
// CIU register-path bus between the PIU requesters,
// the arbiter and the CIU regs block.
interface ct_ciu_regs_piu_arb_if #(
  parameter int NUM_PIU = 4
);
  logic [NUM_PIU-1:0]    piu_arb_sel;
  logic [NUM_PIU*16-1:0] piu_arb_op;
  logic [NUM_PIU*64-1:0] piu_arb_wdata;
  logic                  arb_regs_sel;
  logic [15:0]           arb_regs_op;
  logic [63:0]           arb_regs_wdata;
  logic                  regs_arb_cmplt;
  logic [63:0]           regs_arb_rdata;
  logic [NUM_PIU-1:0]    arb_piu_cmplt;
  logic [63:0]           arb_piu_rdata;
  logic                  arb_piu_err;
  logic                  arb_busy;

  // arbiter side
  modport slave (
    input  piu_arb_sel,
    input  piu_arb_op,
    input  piu_arb_wdata,
    input  regs_arb_cmplt,
    input  regs_arb_rdata,
    output arb_regs_sel,
    output arb_regs_op,
    output arb_regs_wdata,
    output arb_piu_cmplt,
    output arb_piu_rdata,
    output arb_piu_err,
    output arb_busy
  );

  // requester / regs side
  modport master (
    output piu_arb_sel,
    output piu_arb_op,
    output piu_arb_wdata,
    output regs_arb_cmplt,
    output regs_arb_rdata,
    input  arb_regs_sel,
    input  arb_regs_op,
    input  arb_regs_wdata,
    input  arb_piu_cmplt,
    input  arb_piu_rdata,
    input  arb_piu_err,
    input  arb_busy
  );
endinterface

// File: rtl/ct_ciu_regs_piu_arb.sv
// Round-robin arbiter for the CIU register path with
// one outstanding access and a timeout watchdog.
module ct_ciu_regs_piu_arb #(
  parameter int NUM_PIU     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  ct_ciu_regs_piu_arb_if.slave   bus
);
  localparam int IW = $clog2(NUM_PIU);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_PIU - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_grant;
  logic [CW-1:0]      r_cnt;
  logic               r_regs_sel;
  logic [15:0]        r_regs_op;
  logic [63:0]        r_regs_wdata;
  logic [NUM_PIU-1:0] r_piu_cmplt;
  logic [63:0]        r_piu_rdata;
  logic               r_piu_err;
  logic               r_busy;

  logic               w_any;
  logic [IW-1:0]      w_pick;
  logic [IW-1:0]      w_idx;
  logic [15:0]        w_op;
  logic [63:0]        w_wdata;
  logic [NUM_PIU-1:0] w_gnt_oh;
  logic [IW-1:0]      w_next_ptr;

  // first requester at or after rr_ptr, with wrap
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = 0; k < NUM_PIU; k++) begin
      if (int'(r_rr_ptr) + k >= NUM_PIU)
        w_idx = IW'(int'(r_rr_ptr) + k - NUM_PIU);
      else
        w_idx = IW'(int'(r_rr_ptr) + k);
      if (!w_any && bus.piu_arb_sel[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // op/wdata slice of the picked requester
  always_comb begin
    w_op    = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_PIU; i++) begin
      if (w_pick == IW'(i)) begin
        w_op    = bus.piu_arb_op[16*i +: 16];
        w_wdata = bus.piu_arb_wdata[64*i +: 64];
      end
    end
  end

  assign w_gnt_oh =
    {{(NUM_PIU-1){1'b0}}, 1'b1} << r_grant;
  assign w_next_ptr =
    (r_grant == IDX_LAST) ? '0 : r_grant + 1'b1;

  // arbitration FSM; every output is a flop
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_cnt        <= '0;
      r_regs_sel   <= 1'b0;
      r_regs_op    <= '0;
      r_regs_wdata <= '0;
      r_piu_cmplt  <= '0;
      r_piu_rdata  <= '0;
      r_piu_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant      <= w_pick;
            r_regs_op    <= w_op;
            r_regs_wdata <= w_wdata;
            r_regs_sel   <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_regs_sel <= 1'b0;
          r_cnt      <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.regs_arb_cmplt) begin
            r_piu_rdata <= bus.regs_arb_rdata;
            r_piu_err   <= 1'b0;
            r_piu_cmplt <= w_gnt_oh;
            r_state     <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_piu_rdata <= '1;
            r_piu_err   <= 1'b1;
            r_piu_cmplt <= w_gnt_oh;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_piu_cmplt <= '0;
          r_rr_ptr    <= w_next_ptr;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.arb_regs_sel   = r_regs_sel;
  assign bus.arb_regs_op    = r_regs_op;
  assign bus.arb_regs_wdata = r_regs_wdata;
  assign bus.arb_piu_cmplt  = r_piu_cmplt;
  assign bus.arb_piu_rdata  = r_piu_rdata;
  assign bus.arb_piu_err    = r_piu_err;
  assign bus.arb_busy       = r_busy;
endmodule

// File: tb/tb_ct_ciu_regs_piu_arb.sv
// Directed bench for ct_ciu_regs_piu_arb.
// NUM_PIU=4, TIMEOUT_CYC=16.
module tb_ct_ciu_regs_piu_arb;
  localparam int NP = 4;
  localparam int TC = 16;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   n_fail;

  ct_ciu_regs_piu_arb_if #(.NUM_PIU(NP)) bus ();

  ct_ciu_regs_piu_arb #(
    .NUM_PIU    (NP),
    .TIMEOUT_CYC(TC)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  // one transaction from an IDLE cycle, cmplt 1 cycle after sel
  task automatic txn(
    input logic [3:0]  sel,
    input int          g,
    input logic [63:0] rd
  );
    bus.piu_arb_sel = sel;
    chk("txn_idle_busy", 64'(bus.arb_busy), 0);
    tick();
    chk("txn_issue_sel", 64'(bus.arb_regs_sel), 1);
    chk("txn_issue_op", 64'(bus.arb_regs_op),
        64'h0100 + 64'(g));
    chk("txn_issue_wd", bus.arb_regs_wdata,
        64'h1000 + 64'(g));
    tick();
    chk("txn_wait_sel", 64'(bus.arb_regs_sel), 0);
    bus.regs_arb_cmplt = 1'b1;
    bus.regs_arb_rdata = rd;
    tick();
    bus.regs_arb_cmplt = 1'b0;
    chk("txn_cmplt", 64'(bus.arb_piu_cmplt),
        64'd1 << g);
    chk("txn_rdata", bus.arb_piu_rdata, rd);
    chk("txn_err", 64'(bus.arb_piu_err), 0);
    tick();
  endtask

  initial begin
    logic [3:0] seen;
    n_pass  = 0;
    n_total = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    bus.piu_arb_sel    = '0;
    bus.piu_arb_op     = '0;
    bus.piu_arb_wdata  = '0;
    bus.regs_arb_cmplt = 1'b0;
    bus.regs_arb_rdata = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 64'(bus.arb_busy), 0);
    chk("rst_sel", 64'(bus.arb_regs_sel), 0);
    chk("rst_op", 64'(bus.arb_regs_op), 0);
    chk("rst_cmplt", 64'(bus.arb_piu_cmplt), 0);
    chk("rst_rdata", bus.arb_piu_rdata, 0);
    chk("rst_err", 64'(bus.arb_piu_err), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // single request from PIU1
    bus.piu_arb_sel   = 4'b0010;
    bus.piu_arb_op    = {16'h0, 16'h0, 16'h0003, 16'h0};
    bus.piu_arb_wdata = {64'h0, 64'h0, 64'h1234, 64'h0};
    tick();
    chk("t1_sel", 64'(bus.arb_regs_sel), 1);
    chk("t1_op", 64'(bus.arb_regs_op), 64'h3);
    chk("t1_wd", bus.arb_regs_wdata, 64'h1234);
    tick();
    chk("t1_sel_off", 64'(bus.arb_regs_sel), 0);
    chk("t1_busy", 64'(bus.arb_busy), 1);
    tick();
    bus.regs_arb_cmplt = 1'b1;
    bus.regs_arb_rdata = 64'hABCD;
    chk("t1_no_early", 64'(bus.arb_piu_cmplt), 0);
    tick();
    bus.regs_arb_cmplt = 1'b0;
    bus.piu_arb_sel    = '0;
    chk("t1_cmplt", 64'(bus.arb_piu_cmplt), 4'b0010);
    chk("t1_rdata", bus.arb_piu_rdata, 64'hABCD);
    chk("t1_err", 64'(bus.arb_piu_err), 0);
    chk("t1_op_hold", 64'(bus.arb_regs_op), 64'h3);
    tick();
    chk("t1_cmplt_off", 64'(bus.arb_piu_cmplt), 0);
    chk("t1_idle", 64'(bus.arb_busy), 0);
    chk("t1_rd_hold", bus.arb_piu_rdata, 64'hABCD);

    // round robin from rr_ptr=0
    rst_n = 1'b0;
    #2;
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < NP; i++) begin
      bus.piu_arb_op[16*i +: 16]    = 16'h0100 + 16'(i);
      bus.piu_arb_wdata[64*i +: 64] = 64'h1000 + 64'(i);
    end
    txn(4'b1111, 0, 64'h10);
    txn(4'b1111, 1, 64'h11);
    txn(4'b1111, 2, 64'h12);
    txn(4'b1111, 3, 64'h13);
    txn(4'b1111, 0, 64'h14);
    txn(4'b0100, 2, 64'h15);
    txn(4'b1001, 3, 64'h16);
    txn(4'b1001, 0, 64'h17);
    bus.piu_arb_sel = '0;

    // timeout on PIU2 (rr_ptr=1)
    bus.piu_arb_sel = 4'b0100;
    tick();
    chk("t3_sel", 64'(bus.arb_regs_sel), 1);
    tick();
    seen = '0;
    for (int k = 1; k < TC; k++) begin
      tick();
      seen |= bus.arb_piu_cmplt;
    end
    chk("t3_no_early", 64'(seen), 0);
    tick();
    bus.piu_arb_sel = '0;
    chk("t3_cmplt", 64'(bus.arb_piu_cmplt), 4'b0100);
    chk("t3_err", 64'(bus.arb_piu_err), 1);
    chk("t3_rdata", bus.arb_piu_rdata, '1);
    tick();

    // cmplt on the terminal-count cycle wins
    bus.piu_arb_sel = 4'b0100;
    tick();
    tick();
    for (int k = 1; k < TC; k++) tick();
    bus.regs_arb_cmplt = 1'b1;
    bus.regs_arb_rdata = 64'h5A5A;
    tick();
    bus.regs_arb_cmplt = 1'b0;
    bus.piu_arb_sel    = '0;
    chk("t3b_cmplt", 64'(bus.arb_piu_cmplt), 4'b0100);
    chk("t3b_err", 64'(bus.arb_piu_err), 0);
    chk("t3b_rdata", bus.arb_piu_rdata, 64'h5A5A);
    tick();

    // stray cmplt in IDLE and in ISSUE
    bus.regs_arb_cmplt = 1'b1;
    tick();
    bus.regs_arb_cmplt = 1'b0;
    chk("t4_idle_busy", 64'(bus.arb_busy), 0);
    chk("t4_idle_cm", 64'(bus.arb_piu_cmplt), 0);
    tick();
    chk("t4_idle_cm2", 64'(bus.arb_piu_cmplt), 0);
    bus.piu_arb_sel = 4'b0001;
    tick();
    bus.regs_arb_cmplt = 1'b1;
    bus.regs_arb_rdata = 64'hDEAD;
    chk("t4_issue", 64'(bus.arb_regs_sel), 1);
    tick();
    bus.regs_arb_cmplt = 1'b0;
    chk("t4_wait_cm", 64'(bus.arb_piu_cmplt), 0);
    chk("t4_wait_busy", 64'(bus.arb_busy), 1);
    tick();
    chk("t4_wait_cm2", 64'(bus.arb_piu_cmplt), 0);
    bus.regs_arb_cmplt = 1'b1;
    bus.regs_arb_rdata = 64'h77;
    tick();
    bus.regs_arb_cmplt = 1'b0;
    bus.piu_arb_sel    = '0;
    chk("t4_cmplt", 64'(bus.arb_piu_cmplt), 4'b0001);
    chk("t4_rdata", bus.arb_piu_rdata, 64'h77);
    tick();

    // async reset in WAIT
    bus.piu_arb_sel = 4'b0100;
    tick();
    tick();
    bus.piu_arb_sel = '0;
    chk("t5_pre_op", 64'(bus.arb_regs_op), 64'h0102);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(bus.arb_busy), 0);
    chk("t5_op", 64'(bus.arb_regs_op), 0);
    chk("t5_wd", bus.arb_regs_wdata, 0);
    chk("t5_rdata", bus.arb_piu_rdata, 0);
    chk("t5_cmplt", 64'(bus.arb_piu_cmplt), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    txn(4'b1111, 0, 64'h21);

    // back-to-back PIU1
    txn(4'b0010, 1, 64'h31);
    txn(4'b0010, 1, 64'h32);
    bus.piu_arb_sel = '0;
    tick();
    chk("t6_idle", 64'(bus.arb_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
